core_arb: RTL and testbench

CORE_ARB -- requirements
Module: core_arb

---
 rtl/core_arb_pkg.sv | 13 +
 rtl/core_arb_fifo.sv | 62 ++++++
 rtl/core_arb.sv | 170 +++++++++++++++++
 tb/tb_core_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_arb_pkg.sv
// Shared types for the two-requester core arbiter.
package core_arb_pkg;

    typedef enum logic {
        R0 = 1'b0,
        R1 = 1'b1
    } req_id_t;

    function automatic req_id_t other_id(input req_id_t id);
        return (id == R0) ? R1 : R0;
    endfunction

endpackage

// File: rtl/core_arb_fifo.sv
// In-order FIFO of requester IDs for outstanding transactions; DEPTH must be a power of two.
module core_arb_fifo
    import core_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     push,
    input  logic                     pop,
    input  req_id_t                  id_in,
    output req_id_t                  id_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

    req_id_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the ID storage is deliberately not reset; count gates every read, so stale entries are never observed.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= id_in;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointer width is log2(DEPTH), so the increment wraps modulo DEPTH.
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign id_out = mem[rd_ptr];
    assign full   = (count == FULL_COUNT);
    assign empty  = (count == '0);

endmodule

// File: rtl/core_arb.sv
// Two-requester arbiter onto one shared slave port with in-order response routing.
// Define CORE_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to r0.
module core_arb
    import core_arb_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic              aclk,
    input  logic              areset,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [DW/8-1:0]   r0_be,
    input  logic [AW-1:0]     r0_addr,
    input  logic [DW-1:0]     r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DW-1:0]     r0_rdata,
    output logic              r0_err,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [DW/8-1:0]   r1_be,
    input  logic [AW-1:0]     r1_addr,
    input  logic [DW-1:0]     r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DW-1:0]     r1_rdata,
    output logic              r1_err,

    output logic              s_req,
    output logic              s_we,
    output logic [DW/8-1:0]   s_be,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    input  logic              s_gnt,
    input  logic              s_rvalid,
    input  logic [DW-1:0]     s_rdata,
    input  logic              s_err,

    output logic              unexp_rsp
);

    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("core_arb: DEPTH must be a power of two and at least 2");
    end

    req_id_t          sel;
    req_id_t          locked_id;
    req_id_t          head_id;
    logic             locked_q;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             any_req;
    logic             both_req;
    logic             locked_live;

`ifdef CORE_ARB_ROUND_ROBIN_EN
    req_id_t          last_gnt;
`endif

    assign any_req     = r0_req || r1_req;
    assign both_req    = r0_req && r1_req;
    assign locked_live = locked_q && ((locked_id == R0) ? r0_req : r1_req);

    // A request left waiting on s_gnt keeps its slot while its requester still asks.
    always_comb begin
        sel = R0;
        if (locked_live) begin
            sel = locked_id;
        end else if (both_req) begin
`ifdef CORE_ARB_ROUND_ROBIN_EN
            sel = other_id(last_gnt);
`else
            sel = R0;
`endif
        end else if (r1_req) begin
            sel = R1;
        end
    end

    // Only registered occupancy gates s_req, so s_rvalid never feeds the request path.
    assign s_req = !areset && any_req && !full;

    always_comb begin
        s_we    = 1'b0;
        s_be    = '0;
        s_addr  = '0;
        s_wdata = '0;
        if (s_req) begin
            if (sel == R1) begin
                s_we    = r1_we;
                s_be    = r1_be;
                s_addr  = r1_addr;
                s_wdata = r1_wdata;
            end else begin
                s_we    = r0_we;
                s_be    = r0_be;
                s_addr  = r0_addr;
                s_wdata = r0_wdata;
            end
        end
    end

    assign push   = s_req && s_gnt;
    assign r0_gnt = push && (sel == R0);
    assign r1_gnt = push && (sel == R1);

    assign pop       = s_rvalid && !empty;
    assign r0_rvalid = pop && (head_id == R0);
    assign r1_rvalid = pop && (head_id == R1);
    assign r0_rdata  = r0_rvalid ? s_rdata : '0;
    assign r1_rdata  = r1_rvalid ? s_rdata : '0;
    assign r0_err    = r0_rvalid && s_err;
    assign r1_err    = r1_rvalid && s_err;

    core_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (push),
        .pop    (pop),
        .id_in  (sel),
        .id_out (head_id),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            locked_q  <= 1'b0;
            locked_id <= R0;
            unexp_rsp <= 1'b0;
        end else begin
            locked_q <= s_req && !s_gnt;
            if (s_req) begin
                locked_id <= sel;
            end
            if (s_rvalid && empty) begin
                unexp_rsp <= 1'b1;
            end
        end
    end

`ifdef CORE_ARB_ROUND_ROBIN_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            last_gnt <= R1;
        end else if (push) begin
            last_gnt <= sel;
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (!areset) begin
            assert (count <= CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_core_arb.sv
// Self-checking bench for core_arb: queue-based reference model plus directed scenarios.
module tb_core_arb;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
`ifdef CORE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            aclk = 1'b0;
    logic            areset;
    logic            r0_req, r0_we, r1_req, r1_we;
    logic [DW/8-1:0] r0_be, r1_be;
    logic [AW-1:0]   r0_addr, r1_addr;
    logic [DW-1:0]   r0_wdata, r1_wdata;
    logic            r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [DW-1:0]   r0_rdata, r1_rdata;
    logic            s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [DW/8-1:0] s_be;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic            unexp_rsp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 aclk = ~aclk;

    core_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_dut (
        .aclk(aclk), .areset(areset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_be(r0_be), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_be(r1_be), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err),
        .unexp_rsp(unexp_rsp)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requester IDs in issue order, plus arbitration history.
    bit mq[$];
    bit m_unexp   = 1'b0;
    bit m_last    = 1'b1;
    bit m_held    = 1'b0;
    bit m_held_id = 1'b0;

    always @(negedge aclk) begin
        bit            e_sreq, e_sel, head;
        logic [68:0]   e_fields;
        logic [1:0]    e_gnt, e_rv;
        e_rv = 2'b00;
        if (areset) begin
            check("m_rst_outputs", {s_req, s_we, s_be, s_addr, s_wdata, r0_gnt, r1_gnt,
                                    r0_rvalid, r1_rvalid, unexp_rsp}, '0);
            mq.delete();
            m_unexp = 1'b0;
            m_last  = 1'b1;
            m_held  = 1'b0;
        end else begin
            e_sreq = (r0_req || r1_req) && (mq.size() < DEPTH);
            if (m_held && (m_held_id ? r1_req : r0_req)) e_sel = m_held_id;
            else if (r0_req && r1_req)                    e_sel = RR ? !m_last : 1'b0;
            else                                          e_sel = r1_req;
            e_fields = !e_sreq ? '0 :
                       e_sel ? {r1_we, r1_be, r1_addr, r1_wdata} : {r0_we, r0_be, r0_addr, r0_wdata};
            e_gnt = {e_sreq && s_gnt && e_sel, e_sreq && s_gnt && !e_sel};
            if (s_rvalid && mq.size() > 0) begin
                head = mq[0];
                e_rv = head ? 2'b10 : 2'b01;
            end
            check("m_s_req", s_req, e_sreq);
            check("m_s_fields", {s_we, s_be, s_addr, s_wdata}, e_fields);
            check("m_gnt", {r1_gnt, r0_gnt}, e_gnt);
            check("m_rvalid", {r1_rvalid, r0_rvalid}, e_rv);
            if (e_rv[0]) check("m_r0_rsp", {r0_err, r0_rdata}, {s_err, s_rdata});
            if (e_rv[1]) check("m_r1_rsp", {r1_err, r1_rdata}, {s_err, s_rdata});
            check("m_unexp_rsp", unexp_rsp, m_unexp);
            if (s_rvalid) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else               m_unexp = 1'b1;
            end
            if (e_sreq && s_gnt) begin
                mq.push_back(e_sel);
                m_last = e_sel;
            end
            m_held    = e_sreq && !s_gnt;
            m_held_id = e_sel;
        end
    end

    task automatic idle();
        r0_req = 0; r0_we = 0; r0_be = '0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_be = '0; r1_addr = '0; r1_wdata = '0;
        s_gnt = 0; s_rvalid = 0; s_rdata = '0; s_err = 0;
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
    endtask

    initial begin
        idle();
        areset = 1'b1;
        // Reset holds every output low even with a live request.
        cyc(); r0_req = 1; r0_addr = 32'h40;
        sample();
        check("rst_s_req", s_req, 0);
        check("rst_r0_gnt", r0_gnt, 0);
        check("rst_unexp", unexp_rsp, 0);
        cyc(); idle(); areset = 1'b0;

        // Single read from r0, response next cycle.
        cyc(); r0_req = 1; r0_addr = 32'h100; r0_be = 4'hf; s_gnt = 1;
        sample();
        check("t1_r0_gnt", r0_gnt, 1);
        check("t1_r1_gnt", r1_gnt, 0);
        check("t1_s_addr", s_addr, 32'h100);
        cyc(); idle(); s_rvalid = 1; s_rdata = 32'hDEADBEEF;
        sample();
        check("t1_r0_rvalid", r0_rvalid, 1);
        check("t1_r0_rdata", r0_rdata, 32'hDEADBEEF);
        check("t1_r1_rvalid", r1_rvalid, 0);

        // Both requesting for four cycles from a fresh reset.
        cyc(); idle(); areset = 1'b1;
        cyc(); areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            r0_req = 1; r1_req = 1; r0_addr = 32'h200 + i; r1_addr = 32'h300 + i;
            s_gnt = 1; s_rvalid = (i > 0); s_rdata = i;
            sample();
            check("t2_one_gnt", r0_gnt ^ r1_gnt, 1);
            check("t2_grant_id", r1_gnt, RR ? i[0] : 1'b0);
        end
        cyc(); idle(); s_rvalid = 1;
        cyc(); idle();

        // Fill to DEPTH, then response and request in the same cycle.
        cyc(); r0_req = 1; s_gnt = 1;
        sample(); check("t3_g0", r0_gnt, 1);
        cyc(); idle(); r1_req = 1; s_gnt = 1;
        sample(); check("t3_g1", r1_gnt, 1);
        cyc(); idle(); r0_req = 1; r0_addr = 32'h333; s_gnt = 1;
        sample();
        check("t3_full_s_req", s_req, 0);
        check("t3_full_gnt", r0_gnt, 0);
        cyc(); s_rvalid = 1; s_rdata = 32'h33;
        sample();
        check("t3_pop_s_req", s_req, 0);
        check("t3_pop_gnt", r0_gnt, 0);
        check("t3_pop_rvalid", r0_rvalid, 1);
        cyc(); s_rvalid = 0;
        sample(); check("t3_next_gnt", r0_gnt, 1);
        cyc(); idle(); s_rvalid = 1;
        sample(); check("t3_drain_r1", r1_rvalid, 1);
        cyc(); s_rvalid = 1;
        sample(); check("t3_drain_r0", r0_rvalid, 1);
        cyc(); idle();

        // Error response routing follows grant order.
        cyc(); r0_req = 1; r0_we = 1; r0_wdata = 32'hA5A5; s_gnt = 1;
        sample(); check("t4_g0", r0_gnt, 1);
        cyc(); idle(); r1_req = 1; s_gnt = 1;
        sample(); check("t4_g1", r1_gnt, 1);
        cyc(); idle(); s_rvalid = 1; s_err = 0; s_rdata = 32'h11;
        sample();
        check("t4_r0_rv", {r1_rvalid, r0_rvalid}, 2'b01);
        check("t4_r0_err", r0_err, 0);
        cyc(); s_err = 1; s_rdata = 32'h22;
        sample();
        check("t4_r1_rv", {r1_rvalid, r0_rvalid}, 2'b10);
        check("t4_r1_err", r1_err, 1);
        cyc(); idle();

        // Response with nothing outstanding.
        cyc(); s_rvalid = 1; s_rdata = 32'h55;
        sample();
        check("t5_no_rvalid", {r1_rvalid, r0_rvalid}, 2'b00);
        cyc(); idle();
        sample(); check("t5_unexp_set", unexp_rsp, 1);
        cyc(); r0_req = 1; s_gnt = 1;
        cyc(); idle(); s_rvalid = 1;
        sample();
        check("t5_normal_rv", r0_rvalid, 1);
        check("t5_unexp_held", unexp_rsp, 1);
        cyc(); idle(); areset = 1'b1;
        sample(); check("t5_unexp_clr", unexp_rsp, 0);
        cyc(); areset = 1'b0;

        // Reset with a transaction in flight; its late response is unexpected.
        cyc(); r0_req = 1; s_gnt = 1;
        sample(); check("t6_gnt", r0_gnt, 1);
        cyc(); areset = 1'b1;
        sample();
        check("t6_count", u_dut.u_fifo.count, 0);
        check("t6_rst_gnt", r0_gnt, 0);
        cyc(); idle(); areset = 1'b0;
        cyc(); s_rvalid = 1; s_rdata = 32'h77;
        sample(); check("t6_late_drop", {r1_rvalid, r0_rvalid}, 2'b00);
        cyc(); idle();
        sample(); check("t6_unexp", unexp_rsp, 1);

        // A stalled request keeps the slot when the other requester joins.
        cyc(); r1_req = 1; r1_addr = 32'h700;
        sample(); check("t7_sel_r1", s_addr, 32'h700);
        cyc(); r0_req = 1; r0_addr = 32'h600;
        sample();
        check("t7_hold_addr", s_addr, 32'h700);
        check("t7_hold_nogt", {r1_gnt, r0_gnt}, 2'b00);
        cyc(); s_gnt = 1;
        sample(); check("t7_hold_gnt", {r1_gnt, r0_gnt}, 2'b10);
        cyc(); idle(); s_rvalid = 1;
        sample(); check("t7_rsp", r1_rvalid, 1);
        cyc(); idle();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
